energy_norm_pipe: RTL and testbench

//  Normaliser stage downstream of the energy accumulator; turns an unsigned DATAW-bit energy word into float-like (exp, mant, zero) for the monitor's compare/log logic.

---
 rtl/energy_monitor_pkg.sv | 21 ++
 rtl/lzc.sv | 36 +++
 rtl/energy_norm_pipe.sv | 142 ++++++++++++++
 tb/tb_energy_norm_pipe.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/energy_monitor_pkg.sv
// Shared types and width helpers for the energy monitor datapath.
// norm_res_t is the default-width normaliser result seen by downstream consumers.
package energy_monitor_pkg;

  function automatic int expw_f(input int dataw);
    return $clog2(dataw + 1);
  endfunction

  localparam int NORM_DATAW_DEF = 32;
  localparam int NORM_MANTW_DEF = 16;
  localparam int NORM_TAGW_DEF  = 4;
  localparam int NORM_EXPW_DEF  = expw_f(NORM_DATAW_DEF);

  typedef struct packed {
    logic [NORM_EXPW_DEF-1:0]  exp;
    logic [NORM_MANTW_DEF-1:0] mant;
    logic                      zero;
    logic [NORM_TAGW_DEF-1:0]  tag;
  } norm_res_t;

endpackage

// File: rtl/lzc.sv
// Leading-zero counter (REVERSE=0) or trailing-zero counter (REVERSE=1).
// count = N for an all-zero input; valid flags a non-zero input.
module lzc #(
  parameter int N       = 32,
  parameter bit REVERSE = 1'b0,
  localparam int CW     = $clog2(N + 1)
) (
  input  logic [N-1:0]  data_in,
  output logic [CW-1:0] count,
  output logic          valid
);

  logic [N-1:0] vec;

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_order
      if (REVERSE) begin : g_rev
        assign vec[gi] = data_in[N-1-gi];
      end else begin : g_fwd
        assign vec[gi] = data_in[gi];
      end
    end
  endgenerate

  // Ascending scan: the highest set bit writes last and wins.
  always_comb begin
    count = CW'(N);
    for (int i = 0; i < N; i++) begin
      if (vec[i]) count = CW'(N - 1 - i);
    end
  end

  assign valid = |data_in;

endmodule

// File: rtl/energy_norm_pipe.sv
// Two-stage elastic normaliser: energy word -> (exp, mant, zero) plus sideband tag.
// Define ENERGY_NORM_ROUND_EN for round-half-up on the first dropped bit.
module energy_norm_pipe
  import energy_monitor_pkg::*;
#(
  parameter int DATAW  = 32,
  parameter int MANTW  = 16,
  parameter int TAGW   = 4,
  localparam int EXPW  = expw_f(DATAW)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             valid_in,
  output logic             ready_in,
  input  logic [DATAW-1:0] data_in,
  input  logic [TAGW-1:0]  tag_in,
  output logic             valid_out,
  input  logic             ready_out,
  output logic [EXPW-1:0]  exp_out,
  output logic [MANTW-1:0] mant_out,
  output logic             zero_out,
  output logic [TAGW-1:0]  tag_out
);

  generate
    if (MANTW < 1 || MANTW > DATAW) begin : g_bad_mantw
      $error("energy_norm_pipe: MANTW must satisfy 1 <= MANTW <= DATAW");
    end
    if (DATAW < 2) begin : g_bad_dataw
      $error("energy_norm_pipe: DATAW must be >= 2");
    end
    if (TAGW < 1) begin : g_bad_tagw
      $error("energy_norm_pipe: TAGW must be >= 1");
    end
  endgenerate

  logic             s1_valid_reg;
  logic [DATAW-1:0] s1_data_reg;
  logic [TAGW-1:0]  s1_tag_reg;
  logic [EXPW-1:0]  s1_lzc_reg;
  logic             s1_nz_reg;

  logic             s2_valid_reg;
  logic [EXPW-1:0]  s2_exp_reg;
  logic [MANTW-1:0] s2_mant_reg;
  logic             s2_zero_reg;
  logic [TAGW-1:0]  s2_tag_reg;

  logic [EXPW-1:0]  lzc_count;
  logic             lzc_valid;
  logic             s2_ready;
  logic             s1_load;

  lzc #(
    .N       (DATAW),
    .REVERSE (1'b0)
  ) u_lzc (
    .data_in (data_in),
    .count   (lzc_count),
    .valid   (lzc_valid)
  );

  // A stage loads when empty or when its downstream takes its word this cycle.
  assign s2_ready = !s2_valid_reg || ready_out;
  assign s1_load  = !s1_valid_reg || s2_ready;
  assign ready_in = s1_load;

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid_reg <= 1'b0;
      s1_data_reg  <= '0;
      s1_tag_reg   <= '0;
      s1_lzc_reg   <= '0;
      s1_nz_reg    <= 1'b0;
    end else if (s1_load) begin
      s1_valid_reg <= valid_in;
      if (valid_in) begin
        s1_data_reg <= data_in;
        s1_tag_reg  <= tag_in;
        s1_lzc_reg  <= lzc_count;
        s1_nz_reg   <= lzc_valid;
      end
    end
  end

  logic [DATAW-1:0] shifted;
  logic [MANTW-1:0] mant_next;
  logic [EXPW-1:0]  exp_next;

`ifdef ENERGY_NORM_ROUND_EN
  logic guard;
  generate
    if (MANTW < DATAW) begin : g_guard
      assign guard = shifted[DATAW-1-MANTW];
    end else begin : g_no_guard
      assign guard = 1'b0;
    end
  endgenerate
`endif

  always_comb begin
    shifted   = s1_data_reg << s1_lzc_reg;
    mant_next = MANTW'(shifted >> (DATAW - MANTW));
    exp_next  = s1_nz_reg ? (EXPW'(DATAW - 1) - s1_lzc_reg) : '0;
`ifdef ENERGY_NORM_ROUND_EN
    // A zero word shifts to all zeros, so its guard bit is never set.
    if (guard) begin
      if (&mant_next) begin
        mant_next = MANTW'(1) << (MANTW - 1);
        exp_next  = exp_next + 1'b1;
      end else begin
        mant_next = mant_next + 1'b1;
      end
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s2_valid_reg <= 1'b0;
      s2_exp_reg   <= '0;
      s2_mant_reg  <= '0;
      s2_zero_reg  <= 1'b0;
      s2_tag_reg   <= '0;
    end else if (s2_ready) begin
      s2_valid_reg <= s1_valid_reg;
      if (s1_valid_reg) begin
        s2_exp_reg  <= exp_next;
        s2_mant_reg <= mant_next;
        s2_zero_reg <= !s1_nz_reg;
        s2_tag_reg  <= s1_tag_reg;
      end
    end
  end

  assign valid_out = s2_valid_reg;
  assign exp_out   = s2_exp_reg;
  assign mant_out  = s2_mant_reg;
  assign zero_out  = s2_zero_reg;
  assign tag_out   = s2_tag_reg;

endmodule

// File: tb/tb_energy_norm_pipe.sv
// Scoreboard bench for energy_norm_pipe at DATAW=32, MANTW=16, TAGW=4.
// Honours ENERGY_NORM_ROUND_EN in its reference model the same way the design does.
module tb_energy_norm_pipe;
  import energy_monitor_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        valid_in;
  logic        ready_in;
  logic [31:0] data_in;
  logic [3:0]  tag_in;
  logic        valid_out;
  logic        ready_out;
  logic [5:0]  exp_out;
  logic [15:0] mant_out;
  logic        zero_out;
  logic [3:0]  tag_out;

  int n_cmp = 0;
  int n_err = 0;
  bit verbose = 1'b1;

  norm_res_t sb_q[$];
  norm_res_t prev_o;
  bit        prev_stall = 1'b0;

  always #5 clk = ~clk;

  energy_norm_pipe #(.DATAW(32), .MANTW(16), .TAGW(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .valid_in  (valid_in),
    .ready_in  (ready_in),
    .data_in   (data_in),
    .tag_in    (tag_in),
    .valid_out (valid_out),
    .ready_out (ready_out),
    .exp_out   (exp_out),
    .mant_out  (mant_out),
    .zero_out  (zero_out),
    .tag_out   (tag_out)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_cmp++;
    if (obs !== expv) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, expv, $time);
    end
  endtask

  // Reference: locate the MSB directly, normalise, then optionally round.
  function automatic norm_res_t model(input logic [31:0] d, input logic [3:0] t);
    norm_res_t   r;
    int          msb;
    logic [31:0] sh;
    r.tag = t;
    if (d == 32'd0) begin
      r.exp  = '0;
      r.mant = '0;
      r.zero = 1'b1;
      return r;
    end
    msb = 0;
    for (int i = 0; i < 32; i++) if (d[i]) msb = i;
    sh     = d << (31 - msb);
    r.mant = sh[31:16];
    r.exp  = 6'(msb);
    r.zero = 1'b0;
`ifdef ENERGY_NORM_ROUND_EN
    if (sh[15]) begin
      if (r.mant == 16'hFFFF) begin
        r.mant = 16'h8000;
        r.exp  = r.exp + 6'd1;
      end else begin
        r.mant = r.mant + 16'd1;
      end
    end
`endif
    return r;
  endfunction

  function automatic norm_res_t observed();
    norm_res_t r;
    r.exp  = exp_out;
    r.mant = mant_out;
    r.zero = zero_out;
    r.tag  = tag_out;
    return r;
  endfunction

  // Monitor: transfers are decided by values held stable across the falling edge.
  always @(negedge clk) begin
    norm_res_t o;
    norm_res_t e;
    o = observed();
    if (reset) begin
      sb_q.delete();
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("hold_valid", valid_out, 1'b1);
        chk("hold_outputs", o, prev_o);
      end
      if (valid_in && ready_in) sb_q.push_back(model(data_in, tag_in));
      if (valid_out && ready_out) begin
        if (sb_q.size() == 0) begin
          chk("unexpected_out", valid_out, 1'b0);
        end else begin
          e = sb_q.pop_front();
          if (verbose)
            $display("out: exp=%0d mant=0x%04h zero=%0b tag=%0d (exp want %0d mant 0x%04h)",
                     exp_out, mant_out, zero_out, tag_out, e.exp, e.mant);
          chk("scoreboard", o, e);
        end
      end
      prev_stall = valid_out && !ready_out;
      prev_o     = o;
    end
  end

  function automatic logic [31:0] rand_word();
    logic [31:0] ones;
    logic [31:0] w;
    ones = 32'hFFFF_FFFF;
    w    = 32'h0001_FFFF;
    case ($urandom_range(0, 5))
      0:       return 32'd0;
      1:       return ones >> $urandom_range(0, 31);
      2:       return w << $urandom_range(0, 15);
      default: return $urandom >> $urandom_range(0, 31);
    endcase
  endfunction

  // Called one tick after a rising edge with an empty pipe and ready_out high.
  task automatic directed(input logic [31:0] d, input logic [3:0] t,
                          input logic [5:0] ee, input logic [15:0] em, input logic ez);
    $display("in : data=0x%08h tag=%0d", d, t);
    ready_out = 1'b1;
    valid_in  = 1'b1;
    data_in   = d;
    tag_in    = t;
    @(posedge clk); #1;
    valid_in = 1'b0;
    chk("lat1_valid", valid_out, 1'b0);
    @(posedge clk); #1;
    chk("lat2_valid", valid_out, 1'b1);
    chk("dir_exp", exp_out, ee);
    chk("dir_mant", mant_out, em);
    chk("dir_zero", zero_out, ez);
    chk("dir_tag", tag_out, t);
    @(posedge clk); #1;
  endtask

  task automatic drain(input int budget);
    int c;
    valid_in  = 1'b0;
    ready_out = 1'b1;
    c = 0;
    while ((sb_q.size() != 0 || valid_out) && c < budget) begin
      @(posedge clk); #1;
      c++;
    end
    chk("drain_empty", sb_q.size(), 0);
  endtask

  initial begin
    logic [31:0] w[4];
    int idx;
    int cyc;
    int acc_n;
    bit acc;

    reset     = 1'b1;
    valid_in  = 1'b1;
    data_in   = 32'hDEAD_BEEF;
    tag_in    = 4'hA;
    ready_out = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid_out", valid_out, 1'b0);
    chk("rst_ready_in", ready_in, 1'b1);
    chk("rst_exp", exp_out, 6'd0);
    chk("rst_mant", mant_out, 16'd0);
    chk("rst_zero", zero_out, 1'b0);
    chk("rst_tag", tag_out, 4'd0);
    reset    = 1'b0;
    valid_in = 1'b0;
    @(posedge clk); #1;

    directed(32'h0000_0001, 4'd3, 6'd0,  16'h8000, 1'b0);
    directed(32'h8000_0000, 4'd5, 6'd31, 16'h8000, 1'b0);
    directed(32'h0000_0000, 4'd7, 6'd0,  16'h0000, 1'b1);
`ifdef ENERGY_NORM_ROUND_EN
    directed(32'h0001_FFFF, 4'd9, 6'd17, 16'h8000, 1'b0);
    directed(32'hFFFF_FFFF, 4'd1, 6'd32, 16'h8000, 1'b0);
`else
    directed(32'h0001_FFFF, 4'd9, 6'd16, 16'hFFFF, 1'b0);
    directed(32'hFFFF_FFFF, 4'd1, 6'd31, 16'hFFFF, 1'b0);
`endif

    // Stall: four words offered against a blocked consumer for five cycles.
    w[0] = 32'h0000_0100; w[1] = 32'h0012_3456; w[2] = 32'h4000_0001; w[3] = 32'h0000_0003;
    ready_out = 1'b0;
    idx = 0;
    cyc = 0;
    while (idx < 4 && cyc < 30) begin
      if (cyc == 5) begin
        chk("stall_accepted", idx, 2);
        chk("stall_ready_in", ready_in, 1'b0);
        ready_out = 1'b1;
      end
      valid_in = 1'b1;
      data_in  = w[idx];
      tag_in   = 4'(idx + 8);
      @(negedge clk);
      acc = valid_in && ready_in;
      if (acc) $display("in : data=0x%08h tag=%0d", data_in, tag_in);
      @(posedge clk); #1;
      if (acc) idx++;
      cyc++;
    end
    chk("stall_all_in", idx, 4);
    drain(20);

    // Full throughput with both sides always ready.
    verbose   = 1'b0;
    ready_out = 1'b1;
    for (int i = 0; i < 64; i++) begin
      valid_in = 1'b1;
      data_in  = rand_word();
      tag_in   = 4'($urandom);
      @(negedge clk);
      chk("thru_ready_in", ready_in, 1'b1);
      if (i >= 2) chk("thru_valid_out", valid_out, 1'b1);
      @(posedge clk); #1;
    end
    drain(20);

    // Random handshakes on both sides.
    acc_n = 0;
    cyc   = 0;
    while (acc_n < 10000 && cyc < 60000) begin
      valid_in  = ($urandom_range(0, 9) < 7);
      data_in   = rand_word();
      tag_in    = 4'($urandom);
      ready_out = ($urandom_range(0, 9) < 7);
      @(negedge clk);
      if (valid_in && ready_in) acc_n++;
      @(posedge clk); #1;
      cyc++;
    end
    chk("random_words", acc_n, 10000);
    drain(20);

    // Reset with two words in flight; a word offered during reset must vanish.
    verbose   = 1'b1;
    ready_out = 1'b0;
    valid_in  = 1'b1;
    data_in   = 32'h0000_F000;
    tag_in    = 4'd2;
    repeat (3) begin
      @(posedge clk); #1;
      data_in = data_in + 32'd1;
    end
    chk("pre_rst_valid_out", valid_out, 1'b1);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("mid_rst_valid_out", valid_out, 1'b0);
    chk("mid_rst_ready_in", ready_in, 1'b1);
    chk("mid_rst_mant", mant_out, 16'd0);
    reset     = 1'b0;
    valid_in  = 1'b0;
    ready_out = 1'b1;
    repeat (6) begin
      @(negedge clk);
      chk("no_stale_word", valid_out, 1'b0);
    end
    @(posedge clk); #1;
    directed(32'h0000_0400, 4'd6, 6'd10, 16'h8000, 1'b0);
    drain(10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
